// File: rtl/dca_lsu_beat_tracker.sv
// rtl/dca_lsu_beat_tracker.sv - LSU read-beat tracker: pops txn descriptors and walks their data beats
// Optional feature macro: DCA_LSU_BEAT_CHECK_EN (sticky error on beat_last vs. alen disagreement)

module dca_lsu_beat_tracker #(
    parameter int BW_BITADDR  = 35,
    parameter int BW_AXI_DATA = 32,
    localparam int BW_TXN_INFO = BW_BITADDR + 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   txn_rready,
    input  logic [BW_TXN_INFO-1:0] txn_rdata,
    output logic                   txn_rrequest,
    input  logic                   beat_valid,
    input  logic                   beat_last,
    output logic                   beat_ready,
    output logic [BW_BITADDR-1:0]  beat_bitaddr,
    output logic                   beat_first,
    output logic                   beat_end,
    output logic                   matrix_done,
    output logic                   busy,
    output logic                   error
);

    // Each beat advances the bit address by one full data word.
    localparam int DATA_SHIFT = $clog2(BW_AXI_DATA);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                  state;
    logic [7:0]              alen_q;
    logic [7:0]              beat_cnt;
    logic [BW_BITADDR-1:0]   bitaddr_q;
    logic                    continued_q;
    logic                    last_q;
    logic                    matrix_done_q;

    // Queue-head descriptor fields: {matrix_last, continued, alen, bitaddr}.
    logic                    rd_last;
    logic                    rd_continued;
    logic [7:0]              rd_alen;
    logic [BW_BITADDR-1:0]   rd_bitaddr;

    logic                    active;
    logic                    advance_ok;
    logic                    accept;
    logic                    end_hit;
    logic [BW_BITADDR-1:0]   beat_offset;

    assign rd_last      = txn_rdata[BW_TXN_INFO-1];
    assign rd_continued = txn_rdata[BW_TXN_INFO-2];
    assign rd_alen      = txn_rdata[BW_BITADDR+7:BW_BITADDR];
    assign rd_bitaddr   = txn_rdata[BW_BITADDR-1:0];

    assign active     = (state == ST_ACTIVE);
    // rst is folded in so that nothing is popped or accepted in a reset cycle.
    assign advance_ok = enable & ~clear & ~rst;

    assign beat_ready = active & advance_ok;
    assign accept     = beat_valid & beat_ready;
    assign end_hit    = active & (beat_cnt == alen_q);

    // Pop when idle, or on the closing beat so the next txn follows with no bubble.
    assign txn_rrequest = advance_ok & txn_rready & (~active | (accept & end_hit));

    // Offset wraps naturally at the address width.
    assign beat_offset  = BW_BITADDR'(beat_cnt) << DATA_SHIFT;
    assign beat_bitaddr = bitaddr_q + beat_offset;

    assign beat_first  = active & (beat_cnt == 8'd0) & ~continued_q;
    assign beat_end    = end_hit;
    assign busy        = active;
    assign matrix_done = matrix_done_q;

    // Txn sequencing FSM: latch descriptors, count beats, flag the matrix-final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            beat_cnt      <= 8'd0;
            alen_q        <= 8'd0;
            bitaddr_q     <= '0;
            continued_q   <= 1'b0;
            last_q        <= 1'b0;
            matrix_done_q <= 1'b0;
        end else if (clear) begin
            state         <= ST_IDLE;
            beat_cnt      <= 8'd0;
            alen_q        <= 8'd0;
            bitaddr_q     <= '0;
            continued_q   <= 1'b0;
            last_q        <= 1'b0;
            matrix_done_q <= 1'b0;
        end else begin
            // accept already carries enable, so a stalled cycle generates no pulse.
            matrix_done_q <= accept & end_hit & last_q;
            if (txn_rrequest) begin
                state       <= ST_ACTIVE;
                beat_cnt    <= 8'd0;
                alen_q      <= rd_alen;
                bitaddr_q   <= rd_bitaddr;
                continued_q <= rd_continued;
                last_q      <= rd_last;
            end else if (accept && end_hit) begin
                state    <= ST_IDLE;
                beat_cnt <= 8'd0;
            end else if (accept) begin
                beat_cnt <= beat_cnt + 8'd1;
            end
        end
    end

`ifdef DCA_LSU_BEAT_CHECK_EN
    logic error_q;

    // Sticky flag: the interconnect's rlast disagreed with the descriptor's beat count.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            error_q <= 1'b0;
        end else if (accept && (beat_last != end_hit)) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    logic unused_beat_last;

    assign unused_beat_last = beat_last;
    assign error            = 1'b0;
`endif

endmodule

// File: tb/tb_dca_lsu_beat_tracker.sv
// tb/tb_dca_lsu_beat_tracker.sv - self-checking bench for dca_lsu_beat_tracker

module tb_dca_lsu_beat_tracker;

    localparam int BA = 35;
    localparam int BT = BA + 10;

    typedef struct packed {
        logic          last;
        logic          cont;
        logic [7:0]    alen;
        logic [BA-1:0] addr;
    } txn_t;

    typedef struct {
        bit            en, clr, rdy;
        txn_t          td;
        bit            bv, bl;
        bit            req, rdy_o, first, endo, busy, md, chka;
        logic [BA-1:0] addr;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, enable, clear, txn_rready, txn_rrequest;
    logic [BT-1:0] txn_rdata;
    logic          beat_valid, beat_last, beat_ready;
    logic [BA-1:0] beat_bitaddr;
    logic          beat_first, beat_end, matrix_done, busy, error;

    int checks = 0;
    int errors = 0;

    txn_t q[$];
    txn_t cur;
    bit   m_active;
    int   m_idx;
    bit   m_md, m_err;
    logic [BA-1:0] last_addr;

    vec_t tbl[14];

    always #5 clk = ~clk;

    dca_lsu_beat_tracker #(.BW_BITADDR(BA), .BW_AXI_DATA(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .txn_rready(txn_rready), .txn_rdata(txn_rdata), .txn_rrequest(txn_rrequest),
        .beat_valid(beat_valid), .beat_last(beat_last), .beat_ready(beat_ready),
        .beat_bitaddr(beat_bitaddr), .beat_first(beat_first), .beat_end(beat_end),
        .matrix_done(matrix_done), .busy(busy), .error(error)
    );

    function automatic txn_t mk(bit l, bit c, int a, logic [BA-1:0] ad);
        txn_t t;
        t.last = l; t.cont = c; t.alen = 8'(a); t.addr = ad;
        return t;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_end();
        return m_active && (m_idx == int'(cur.alen));
    endfunction

    // One clock of stimulus, compared against the transaction-level model.
    task automatic cycle(input bit r, input bit e, input bit c, input bit v, input bit l);
        bit     en_ok, exp_ready, exp_end, exp_first, acc, exp_req;
        longint ea;
        @(negedge clk);
        rst = r; enable = e; clear = c; beat_valid = v; beat_last = l;
        txn_rready = (q.size() > 0);
        txn_rdata  = (q.size() > 0) ? q[0] : '0;
        #1;
        en_ok     = e && !c && !r;
        exp_ready = m_active && en_ok;
        exp_end   = model_end();
        exp_first = m_active && (m_idx == 0) && !cur.cont;
        acc       = v && exp_ready;
        exp_req   = en_ok && (q.size() > 0) && (!m_active || (acc && exp_end));
        ea        = (longint'(cur.addr) + longint'(m_idx) * 32) % (longint'(1) << BA);
        last_addr = beat_bitaddr;
        if (!r) begin
            chk("req", txn_rrequest, exp_req);
            chk("ready", beat_ready, exp_ready);
        end
        chk("busy", busy, m_active);
        chk("first", beat_first, exp_first);
        chk("end", beat_end, exp_end);
        chk("matrix_done", matrix_done, m_md);
        chk("error", error, m_err);
        if (m_active) chk("bitaddr", beat_bitaddr, ea);
        @(posedge clk);
        if (r || c) begin
            m_active = 0; m_idx = 0; m_md = 0; m_err = 0; cur = '0;
        end else begin
            m_md = acc && exp_end && cur.last;
`ifdef DCA_LSU_BEAT_CHECK_EN
            if (acc && (l != exp_end)) m_err = 1;
`endif
            if (exp_req) begin
                cur = q.pop_front(); m_idx = 0; m_active = 1;
            end else if (acc && exp_end) begin
                m_active = 0; m_idx = 0;
            end else if (acc) begin
                m_idx++;
            end
        end
    endtask

    initial begin
        txn_t a0, ta, tb_, z;
        bit   e_bit;

        z   = '0;
        a0  = mk(1, 0, 3, 35'h100);
        ta  = mk(0, 0, 1, 35'h200);
        tb_ = mk(1, 0, 1, 35'h400);

        //            en clr rdy td   bv bl  req rdy first end busy md chka addr
        tbl[0]  = '{1, 0, 1, a0,  0, 0,  1,  0,  0,   0,  0,   0, 0, 35'h0};
        tbl[1]  = '{1, 0, 0, z,   1, 0,  0,  1,  1,   0,  1,   0, 1, 35'h100};
        tbl[2]  = '{1, 0, 0, z,   1, 0,  0,  1,  0,   0,  1,   0, 1, 35'h120};
        tbl[3]  = '{1, 0, 0, z,   1, 0,  0,  1,  0,   0,  1,   0, 1, 35'h140};
        tbl[4]  = '{1, 0, 0, z,   1, 1,  0,  1,  0,   1,  1,   0, 1, 35'h160};
        tbl[5]  = '{1, 0, 0, z,   0, 0,  0,  0,  0,   0,  0,   1, 0, 35'h0};
        tbl[6]  = '{1, 0, 0, z,   0, 0,  0,  0,  0,   0,  0,   0, 0, 35'h0};
        tbl[7]  = '{1, 0, 1, ta,  1, 0,  1,  0,  0,   0,  0,   0, 0, 35'h0};
        tbl[8]  = '{1, 0, 1, tb_, 1, 0,  0,  1,  1,   0,  1,   0, 1, 35'h200};
        tbl[9]  = '{1, 0, 1, tb_, 1, 1,  1,  1,  0,   1,  1,   0, 1, 35'h220};
        tbl[10] = '{1, 0, 0, z,   1, 0,  0,  1,  1,   0,  1,   0, 1, 35'h400};
        tbl[11] = '{1, 0, 0, z,   1, 1,  0,  1,  0,   1,  1,   0, 1, 35'h420};
        tbl[12] = '{1, 0, 0, z,   0, 0,  0,  0,  0,   0,  0,   1, 0, 35'h0};
        tbl[13] = '{1, 0, 0, z,   0, 0,  0,  0,  0,   0,  0,   0, 0, 35'h0};

        rst = 1; enable = 0; clear = 0; txn_rready = 0; txn_rdata = '0;
        beat_valid = 0; beat_last = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", beat_ready, 0);
        chk("rst_req", txn_rrequest, 0);
        chk("rst_first", beat_first, 0);
        chk("rst_end", beat_end, 0);
        chk("rst_md", matrix_done, 0);
        chk("rst_err", error, 0);
        chk("rst_addr", beat_bitaddr, 0);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            enable = tbl[i].en; clear = tbl[i].clr; txn_rready = tbl[i].rdy;
            txn_rdata = tbl[i].td; beat_valid = tbl[i].bv; beat_last = tbl[i].bl;
            #1;
            chk($sformatf("t%0d_req", i), txn_rrequest, tbl[i].req);
            chk($sformatf("t%0d_ready", i), beat_ready, tbl[i].rdy_o);
            chk($sformatf("t%0d_first", i), beat_first, tbl[i].first);
            chk($sformatf("t%0d_end", i), beat_end, tbl[i].endo);
            chk($sformatf("t%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("t%0d_md", i), matrix_done, tbl[i].md);
            chk($sformatf("t%0d_err", i), error, 0);
            if (tbl[i].chka) chk($sformatf("t%0d_addr", i), beat_bitaddr, tbl[i].addr);
        end

        m_active = 0; m_idx = 0; m_md = 0; m_err = 0; cur = '0;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Address wrap at the top of the bit-address space.
        q.push_back(mk(1, 0, 1, 35'h7_FFFF_FFE0));
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0);
        chk("wrap_beat0", last_addr, 35'h7_FFFF_FFE0);
        cycle(0, 1, 0, 1, 1);
        chk("wrap_beat1", last_addr, 35'h0);
        cycle(0, 1, 0, 0, 0);

        // Flush mid-burst with the next txn already waiting.
        q.push_back(mk(1, 0, 7, 35'h3000));
        q.push_back(mk(1, 1, 2, 35'h800));
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 1, 1, 0);
        cycle(0, 1, 0, 0, 0);
        chk("clear_idle_pop", q.size(), 0);
        cycle(0, 1, 0, 1, 0);
        chk("clear_next_addr", last_addr, 35'h800);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 1, 1);
        cycle(0, 1, 0, 0, 0);

        // Early rlast on beat 1 of a three-beat txn.
        q.push_back(mk(0, 0, 2, 35'h5000));
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 1, 1);
        cycle(0, 1, 0, 1, 1);
`ifdef DCA_LSU_BEAT_CHECK_EN
        e_bit = 1;
`else
        e_bit = 0;
`endif
        chk("err_sticky", error, e_bit);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);

        // Three stalled cycles mid-burst, then resume.
        q.push_back(mk(1, 0, 3, 35'h1000));
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 0);
            chk($sformatf("stall%0d_addr", i), last_addr, 35'h1020);
        end
        cycle(0, 1, 0, 1, 0);
        chk("resume_addr", last_addr, 35'h1020);
        cycle(0, 1, 0, 1, 0);
        cycle(0, 1, 0, 1, 1);
        cycle(0, 1, 0, 0, 0);

        // Reset on the closing beat abandons the txn without a pulse.
        q.push_back(mk(1, 0, 1, 35'h9000));
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 1, 0);
        cycle(1, 1, 0, 1, 1);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            bit r, e, c, v, l, ee;
            if (q.size() < 3 && ($urandom % 3) == 0) begin
                logic [BA-1:0] ad;
                int al;
                ad = BA'({$urandom, $urandom});
                if (($urandom % 4) == 0) ad = 35'h7_FFFF_FF00 | BA'($urandom % 256);
                al = (($urandom % 4) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 3));
                q.push_back(mk($urandom % 2, $urandom % 2, al, ad));
            end
            r  = (($urandom % 150) == 0);
            e  = (($urandom % 6) != 0);
            c  = (($urandom % 40) == 0);
            v  = (($urandom % 4) != 0);
            ee = model_end();
            l  = (($urandom % 8) == 0) ? !ee : ee;
            cycle(r, e, c, v, l);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
